// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: opcodes, ALU op codes, trap causes and sequencer states shared by the multi-cycle control.
package rv_ctrl_pkg;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_RF  = 3'b010;
    localparam logic [2:0] ALU_IF  = 3'b011;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_LD, BRANCH, TRAP
    } state_t;
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: instruction/memory inputs and datapath control strobes of the sequencer.
interface multicycle_control_if #(parameter int CNT_W = 16);
    logic [6:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             ir_write;
    logic             iord;
    logic             branch;
    logic             memread;
    logic             memwrite;
    logic             MemtoReg;
    logic             ALUsrc;
    logic             regWrite;
    logic [2:0]       alu_op;
    logic             instr_done;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, ir_write, iord, branch, memread, memwrite,
               MemtoReg, ALUsrc, regWrite, alu_op, instr_done, trap, trap_cause, retired
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, ir_write, iord, branch, memread, memwrite,
               MemtoReg, ALUsrc, regWrite, alu_op, instr_done, trap, trap_cause, retired
    );
endinterface

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts consecutive not-ready cycles of a memory phase and flags the timeout.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic in_mem_i,
    input  logic mem_ready_i,
    output logic timeout_o
);
    logic [7:0] cnt_q, cnt_d;

    // Held at zero outside memory phases, so every memory phase starts counting from zero.
    assign cnt_d     = (!in_mem_i || mem_ready_i) ? 8'd0 : cnt_q + 8'd1;
    assign timeout_o = in_mem_i && !mem_ready_i && (cnt_q >= 8'(MEM_TIMEOUT));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= 8'd0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle RV32I-subset sequencer driving the shared datapath strobes.
module multicycle_control
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    state_t           state_q, state_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] retired_q;
    logic             in_mem, timeout, done;

    assign in_mem = state_q inside {FETCH, MEM_RD, MEM_WR};

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clock       (clock),
        .reset       (reset),
        .in_mem_i    (in_mem),
        .mem_ready_i (bus.mem_ready),
        .timeout_o   (timeout)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            cause_q   <= CAUSE_NONE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            retired_q <= retired_q + CNT_W'(done);
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            FETCH:    state_d = timeout ? TRAP : bus.mem_ready ? DECODE : FETCH;
            DECODE:
                case (bus.opcode)
                    OP_R:         state_d = EXEC_R;
                    OP_I:         state_d = EXEC_I;
                    OP_LD, OP_ST: state_d = MEM_ADDR;
                    OP_BR:        state_d = BRANCH;
                    default:      state_d = TRAP;
                endcase
            EXEC_R, EXEC_I:        state_d = WB_ALU;
            MEM_ADDR:              state_d = (bus.opcode == OP_ST) ? MEM_WR : MEM_RD;
            MEM_RD:   state_d = timeout ? TRAP : bus.mem_ready ? WB_LD : MEM_RD;
            MEM_WR:   state_d = timeout ? TRAP : bus.mem_ready ? FETCH : MEM_WR;
            WB_ALU, WB_LD, BRANCH: state_d = FETCH;
            default:               state_d = state_q;
        endcase
        // Only memory phases can time out, so any other trap entry is an illegal opcode.
        if (state_d == TRAP && state_q != TRAP) cause_d = timeout ? CAUSE_TIMEOUT : CAUSE_ILLEGAL;
    end

    assign done = (state_q inside {WB_ALU, WB_LD, BRANCH}) || (state_q == MEM_WR && bus.mem_ready);

    assign bus.memread       = state_q inside {FETCH, MEM_RD};
    assign bus.iord          = state_q inside {MEM_RD, MEM_WR};
    assign bus.ir_write      = state_q == FETCH && bus.mem_ready;
    assign bus.pc_write      = state_q == FETCH && bus.mem_ready;
    assign bus.pc_write_cond = state_q == BRANCH && bus.zero;
    assign bus.branch        = state_q == BRANCH;
    assign bus.memwrite      = state_q == MEM_WR;
    assign bus.MemtoReg      = state_q == WB_LD;
    assign bus.ALUsrc        = state_q inside {EXEC_I, MEM_ADDR};
    assign bus.regWrite      = state_q inside {WB_ALU, WB_LD};
    assign bus.alu_op        = state_q == EXEC_R ? ALU_RF :
                               state_q == EXEC_I ? ALU_IF :
                               state_q == BRANCH ? ALU_SUB : ALU_ADD;
    assign bus.instr_done    = done;
    assign bus.trap          = state_q == TRAP;
    assign bus.trap_cause    = cause_q;
    assign bus.retired       = retired_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed checks of the multi-cycle sequencer strobes, traps and retire count.
module tb_multicycle_control;
    import rv_ctrl_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_done = 0;

    multicycle_control_if #(.CNT_W(16)) bus();

    multicycle_control #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // {pc_write, pc_write_cond, ir_write, iord, branch, memread, memwrite, MemtoReg, ALUsrc, regWrite, alu_op, instr_done}
    logic [13:0] s;
    assign s = {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.iord, bus.branch, bus.memread,
                bus.memwrite, bus.MemtoReg, bus.ALUsrc, bus.regWrite, bus.alu_op, bus.instr_done};

    localparam logic [13:0] S_IDLE   = 14'b0000_0000_00_000_0;
    localparam logic [13:0] S_FWAIT  = 14'b0000_0100_00_000_0;
    localparam logic [13:0] S_FRDY   = 14'b1010_0100_00_000_0;
    localparam logic [13:0] S_EXR    = 14'b0000_0000_00_010_0;
    localparam logic [13:0] S_WBALU  = 14'b0000_0000_01_000_1;
    localparam logic [13:0] S_MADDR  = 14'b0000_0000_10_000_0;
    localparam logic [13:0] S_MRD    = 14'b0001_0100_00_000_0;
    localparam logic [13:0] S_WBLD   = 14'b0000_0001_01_000_1;
    localparam logic [13:0] S_MWR    = 14'b0001_0010_00_000_0;
    localparam logic [13:0] S_MWRDY  = 14'b0001_0010_00_000_1;
    localparam logic [13:0] S_BRT    = 14'b0100_1000_00_001_1;
    localparam logic [13:0] S_BRN    = 14'b0000_1000_00_001_1;

    always @(negedge clock) if (bus.instr_done) n_done++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic drive(input logic [6:0] op, input logic rdy, input logic z);
        bus.opcode    = op;
        bus.mem_ready = rdy;
        bus.zero      = z;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog n_chk=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        drive(7'd0, 1'b0, 1'b0);
        chk("rst_strobes", 32'(s), 32'(S_FWAIT));
        chk("rst_trap", 32'(bus.trap), 0);
        chk("rst_cause", 32'(bus.trap_cause), 0);
        chk("rst_retired", 32'(bus.retired), 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        drive(OP_R, 1'b1, 1'b0);
        chk("r_fetch", 32'(s), 32'(S_FRDY));
        tick(); chk("r_decode", 32'(s), 32'(S_IDLE));
        tick(); chk("r_exec", 32'(s), 32'(S_EXR));
        tick(); chk("r_wb", 32'(s), 32'(S_WBALU));
        tick(); chk("r_retired", 32'(bus.retired), 1);

        drive(OP_LD, 1'b1, 1'b0);
        chk("ld_fetch", 32'(s), 32'(S_FRDY));
        tick(); chk("ld_decode", 32'(s), 32'(S_IDLE));
        tick(); chk("ld_addr", 32'(s), 32'(S_MADDR));
        drive(OP_LD, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) drive(OP_LD, 1'b1, 1'b0);
            chk($sformatf("ld_rd%0d", i), 32'(s), 32'(S_MRD));
        end
        tick(); chk("ld_wb", 32'(s), 32'(S_WBLD));
        tick(); chk("ld_retired", 32'(bus.retired), 2);

        drive(OP_ST, 1'b1, 1'b0);
        chk("st_fetch", 32'(s), 32'(S_FRDY));
        tick(); chk("st_decode", 32'(s), 32'(S_IDLE));
        tick(); chk("st_addr", 32'(s), 32'(S_MADDR));
        tick(); chk("st_wr", 32'(s), 32'(S_MWRDY));
        tick(); drive(OP_BR, 1'b1, 1'b1);
        chk("st_after", 32'(s), 32'(S_FRDY));
        chk("st_retired", 32'(bus.retired), 3);

        tick(); chk("bt_decode", 32'(s), 32'(S_IDLE));
        tick(); chk("bt_branch", 32'(s), 32'(S_BRT));
        tick(); drive(OP_BR, 1'b1, 1'b0);
        tick(); tick(); chk("bn_branch", 32'(s), 32'(S_BRN));
        tick(); chk("br_retired", 32'(bus.retired), 5);

        drive(7'b1111111, 1'b1, 1'b0);
        tick(); chk("ill_decode", 32'(s), 32'(S_IDLE));
        tick(); chk("ill_trap", 32'(bus.trap), 1);
        chk("ill_cause", 32'(bus.trap_cause), 1);
        for (int i = 0; i < 20; i++) begin
            drive(OP_R, 1'(i % 2), 1'b0);
            chk($sformatf("ill_hold%0d", i), 32'({bus.trap, s}), 32'({1'b1, S_IDLE}));
            tick();
        end
        chk("ill_retired", 32'(bus.retired), 5);

        #1 reset = 1'b1;
        #1 chk("to_rst_trap", 32'(bus.trap), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        drive(OP_R, 1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("to_wait%0d", i), 32'({bus.trap, s}), 32'({1'b0, S_FWAIT}));
            tick();
        end
        chk("to_trap", 32'(bus.trap), 1);
        chk("to_cause", 32'(bus.trap_cause), 2);

        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        drive(OP_R, 1'b0, 1'b0);
        for (int i = 1; i < 16; i++) tick();
        drive(OP_R, 1'b1, 1'b0);
        chk("edge_fetch", 32'(s), 32'(S_FRDY));
        tick(); chk("edge_notrap", 32'({bus.trap, s}), 32'({1'b0, S_IDLE}));
        tick(); tick(); tick();
        drive(OP_ST, 1'b1, 1'b0);
        chk("edge_retired", 32'(bus.retired), 1);
        tick(); tick(); drive(OP_ST, 1'b0, 1'b0);
        tick(); chk("mw_active", 32'(s), 32'(S_MWR));
        tick(); chk("mw_wait", 32'(s), 32'(S_MWR));
        #1 reset = 1'b1;
        #1 chk("mw_rst_strobes", 32'(s), 32'(S_FWAIT));
        chk("mw_rst_retired", 32'(bus.retired), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        drive(OP_BR, 1'b1, 1'b0);
        chk("mw_fetch", 32'(s), 32'(S_FRDY));
        tick(); chk("mw_decode", 32'(s), 32'(S_IDLE));
        tick(); chk("mw_branch", 32'(s), 32'(S_BRN));
        tick(); chk("mw_retired", 32'(bus.retired), 1);
        chk("done_pulses", 32'(n_done), 7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
